// File: rtl/nw_fill_ctrl.sv
// Needleman-Wunsch score-matrix sequencer: writes the gap-penalty border, then walks
// cells (1,1)..(len_a,len_b) row-major through READ -> CALC -> WRITE with the PE.
module nw_fill_ctrl #(
    parameter int N       = 128,
    parameter int BitAddr = $clog2(N),
    parameter int GAP     = -2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BitAddr:0] len_a,
    input  logic [BitAddr:0] len_b,
    input  logic [8:0]       pe_max,
    input  logic             pe_valid,
    output logic             en_init,
    output logic             en_ins_read,
    output logic             we,
    output logic [BitAddr:0] addr,
    output logic [8:0]       data,
    output logic [BitAddr:0] i,
    output logic [BitAddr:0] j,
    output logic [8:0]       max,
    output logic             calc_en,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int IW = BitAddr + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_CALC  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(N);
    localparam logic [8:0]    GAP9     = 9'(GAP);

    logic [2:0]    r_state;
    logic [IW-1:0] r_la;
    logic [IW-1:0] r_lb;
    logic [IW-1:0] r_kmax;
    logic [IW-1:0] r_addr;
    logic [8:0]    r_data;
    logic [IW-1:0] r_i;
    logic [IW-1:0] r_j;
    logic [8:0]    r_max;
    logic          r_en_init;
    logic          r_en_read;
    logic          r_we;
    logic          r_calc_en;
    logic          r_busy;
    logic          r_done;
    logic          r_err;

    logic          w_len_ok;
    logic [IW-1:0] w_kmax;

    assign w_len_ok = (len_a != '0) && (len_b != '0) && (len_a <= IDX_MAX) && (len_b <= IDX_MAX);
    assign w_kmax   = (len_a > len_b) ? len_a : len_b;

    // NOTE: every register here is state, so all updates are non-blocking; defaults
    // at the top of the else-branch make calc_en/done/err single-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_la      <= '0;
            r_lb      <= '0;
            r_kmax    <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_max     <= '0;
            r_en_init <= 1'b0;
            r_en_read <= 1'b0;
            r_we      <= 1'b0;
            r_calc_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_calc_en <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_la   <= len_a;
                        r_lb   <= len_b;
                        r_kmax <= w_kmax;
                        r_busy <= 1'b1;
                        if (!w_len_ok) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state   <= S_INIT;
                            r_en_init <= 1'b1;
                            r_we      <= 1'b1;
                            r_addr    <= '0;
                            r_data    <= '0;
                        end
                    end
                end
                S_INIT: begin
                    if (r_addr == r_kmax) begin
                        r_state   <= S_READ;
                        r_en_init <= 1'b0;
                        r_we      <= 1'b0;
                        r_en_read <= 1'b1;
                        r_i       <= IDX_ONE;
                        r_j       <= IDX_ONE;
                    end else begin
                        r_addr <= r_addr + IDX_ONE;
                        r_data <= r_data + GAP9;
                    end
                end
                S_READ: begin
                    r_state   <= S_CALC;
                    r_en_read <= 1'b0;
                    r_calc_en <= 1'b1;
                end
                S_CALC: begin
                    if (pe_valid) begin
                        r_max     <= pe_max;
                        r_state   <= S_WRITE;
                        r_en_read <= 1'b1;
                        r_we      <= 1'b1;
                    end
                end
                S_WRITE: begin
                    r_we <= 1'b0;
                    if (r_j < r_lb) begin
                        r_j     <= r_j + IDX_ONE;
                        r_state <= S_READ;
                    end else if (r_i < r_la) begin
                        r_i     <= r_i + IDX_ONE;
                        r_j     <= IDX_ONE;
                        r_state <= S_READ;
                    end else begin
                        r_state   <= S_DONE;
                        r_en_read <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_en_init <= 1'b0;
                    r_en_read <= 1'b0;
                    r_we      <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign en_init     = r_en_init;
    assign en_ins_read = r_en_read;
    assign we          = r_we;
    assign addr        = r_addr;
    assign data        = r_data;
    assign i           = r_i;
    assign j           = r_j;
    assign max         = r_max;
    assign calc_en     = r_calc_en;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;

endmodule

// File: tb/tb_nw_fill_ctrl.sv
// Directed bench for nw_fill_ctrl: table of runs checked against a small scoreboard,
// plus hand-written reset-abort and ignored-stimulus sequences.
module tb_nw_fill_ctrl;

    localparam int N   = 128;
    localparam int GAP = -2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] len_a;
    logic [7:0] len_b;
    logic [8:0] pe_max;
    logic       pe_valid;
    logic       en_init;
    logic       en_ins_read;
    logic       we;
    logic [7:0] addr;
    logic [8:0] data;
    logic [7:0] i;
    logic [7:0] j;
    logic [8:0] max;
    logic       calc_en;
    logic       busy;
    logic       done;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    nw_fill_ctrl #(.N(N), .GAP(GAP)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .len_a       (len_a),
        .len_b       (len_b),
        .pe_max      (pe_max),
        .pe_valid    (pe_valid),
        .en_init     (en_init),
        .en_ins_read (en_ins_read),
        .we          (we),
        .addr        (addr),
        .data        (data),
        .i           (i),
        .j           (j),
        .max         (max),
        .calc_en     (calc_en),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int la;
        int lb;
        int dly;        // CALC cycles the PE waits before pe_valid
        bit inj;        // pulse start and pe_valid during a READ
        bit exp_err;
        int exp_cycles; // cycles from start edge until done is visible
        int exp_last_data;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic logic [8:0] pe_val(input int a, input int b);
        pe_val = 9'(a * 7 - b * 13 + 3);
    endfunction

    function automatic int any_out();
        any_out = int'(|{en_init, en_ins_read, we, addr, data, i, j, max, calc_en, busy, done, err});
    endfunction

    task automatic run_case(input vec_t v);
        int  k = 0, mi = 1, mj = 1, wcnt = 0;
        int  n_init = 0, init_err = 0, n_wr = 0, wr_err = 0, n_calc = 0, prot = 0;
        int  last_addr = -1, last_data = -1, last_i = -1, last_j = -1;
        int  done_c = -1, err_seen = 0;
        bit  injected = 0, start_hold = 0;
        @(negedge clk);
        len_a    = 8'(v.la);
        len_b    = 8'(v.lb);
        start    = 1'b1;
        pe_valid = (v.dly == 0);
        pe_max   = pe_val(1, 1);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= v.exp_cycles + 60; c++) begin
            if ((en_init && en_ins_read) || (we && !en_init && !en_ins_read) ||
                (calc_en && (en_ins_read || we)) || !busy)
                prot++;
            if (en_init) begin
                if (int'(addr) != k || data != 9'(k * GAP) || !we) init_err++;
                last_addr = int'(addr);
                last_data = int'(data);
                k++;
                n_init++;
            end
            if (we && en_ins_read) begin
                if (int'(i) != mi || int'(j) != mj || max != pe_val(mi, mj)) wr_err++;
                last_i = int'(i);
                last_j = int'(j);
                n_wr++;
                if (mj < v.lb) mj++;
                else begin mi++; mj = 1; end
            end
            if (calc_en) n_calc++;
            if (done) begin
                done_c   = c;
                err_seen = int'(err);
                break;
            end
            if (start_hold) begin
                start      = 1'b0;
                start_hold = 1'b0;
            end
            pe_max = pe_val(mi, mj);
            if (v.dly == 0) pe_valid = 1'b1;
            else if (calc_en) begin
                wcnt     = v.dly;
                pe_valid = 1'b0;
            end else if (wcnt > 0) begin
                wcnt--;
                pe_valid = (wcnt == 0);
            end else pe_valid = 1'b0;
            if (v.inj && !injected && en_ins_read && !we && mi == 2) begin
                start      = 1'b1;
                len_a      = 8'd1;
                len_b      = 8'd1;
                pe_valid   = 1'b1;
                injected   = 1'b1;
                start_hold = 1'b1;
            end
            @(negedge clk);
        end
        check($sformatf("done_cycle_%0dx%0d", v.la, v.lb), done_c, v.exp_cycles);
        check("err_flag", err_seen, int'(v.exp_err));
        check("protocol_violations", prot, 0);
        check("init_writes", n_init, v.exp_err ? 0 : ((v.la > v.lb ? v.la : v.lb) + 1));
        check("init_value_errors", init_err, 0);
        check("cell_writes", n_wr, v.exp_err ? 0 : v.la * v.lb);
        check("cell_write_errors", wr_err, 0);
        check("calc_en_pulses", n_calc, v.exp_err ? 0 : v.la * v.lb);
        if (!v.exp_err) begin
            check("last_init_addr", last_addr, v.la > v.lb ? v.la : v.lb);
            check("last_init_data", last_data, v.exp_last_data);
            check("last_write_i", last_i, v.la);
            check("last_write_j", last_j, v.lb);
        end
        @(negedge clk);
        check("idle_after_done_busy", int'(busy), 0);
        check("done_single_pulse", int'(done), 0);
        if (!v.exp_err) begin
            check("readout_i", int'(i), v.la);
            check("readout_j", int'(j), v.lb);
        end
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{la: 3,   lb: 2,   dly: 0, inj: 0, exp_err: 0, exp_cycles: 23,    exp_last_data: 506};
        vecs[1] = '{la: 3,   lb: 2,   dly: 4, inj: 0, exp_err: 0, exp_cycles: 47,    exp_last_data: 506};
        vecs[2] = '{la: 1,   lb: 1,   dly: 0, inj: 0, exp_err: 0, exp_cycles: 6,     exp_last_data: 510};
        vecs[3] = '{la: 2,   lb: 5,   dly: 1, inj: 0, exp_err: 0, exp_cycles: 47,    exp_last_data: 502};
        vecs[4] = '{la: 0,   lb: 4,   dly: 0, inj: 0, exp_err: 1, exp_cycles: 1,     exp_last_data: 0};
        vecs[5] = '{la: 4,   lb: 129, dly: 0, inj: 0, exp_err: 1, exp_cycles: 1,     exp_last_data: 0};
        vecs[6] = '{la: 3,   lb: 3,   dly: 2, inj: 1, exp_err: 0, exp_cycles: 50,    exp_last_data: 506};
        vecs[7] = '{la: 128, lb: 128, dly: 0, inj: 0, exp_err: 0, exp_cycles: 49282, exp_last_data: 256};

        rst      = 1'b1;
        start    = 1'b0;
        len_a    = '0;
        len_b    = '0;
        pe_max   = '0;
        pe_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs_zero", any_out(), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs_zero", any_out(), 0);

        foreach (vecs[n]) run_case(vecs[n]);

        // Abort a 3x3 run in the middle of the fill, then confirm a clean restart.
        @(negedge clk);
        len_a    = 8'd3;
        len_b    = 8'd3;
        pe_valid = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("midfill_busy_before_reset", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midfill_reset_outputs_zero", any_out(), 0);
        @(negedge clk);
        check("post_reset_stays_idle", any_out(), 0);
        run_case('{la: 2, lb: 2, dly: 0, inj: 0, exp_err: 0, exp_cycles: 16, exp_last_data: 508});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
